bcd_to_bin_seq: RTL



---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_to_bin_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the digit geometry, the controller state encoding and a helper that
// flags a nibble as a legal BCD digit (0..9).
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // A nibble is a legal BCD digit when it does not exceed DIGIT_MAX.
  function automatic logic bcd_nibble_valid(input logic [DIGIT_W-1:0] nib);
    return (nib <= DIGIT_W'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble.
// After each right shift, a digit that reads 8 or more has received a
// half-weight bit from the digit above it (worth 5, not 8), so 3 is removed.
// Ports:
//   din  - shifted BCD nibble
//   dout - corrected nibble
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Only nibbles >= 8 are corrected, so the subtraction never underflows.
  assign dout = (din >= DIGIT_W'(8)) ? (din - DIGIT_W'(3)) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder using reverse double-dabble.
// A packed BCD word is accepted over a valid/ready handshake, converted with
// one shift-and-correct step per clock (BIN_W steps), and returned over a
// second valid/ready handshake. A word containing any nibble above 9 skips
// conversion and is reported with out_err=1 and out_bin=0.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - BCD word present on in_bcd
//   in_ready  - converter idle and able to accept a word
//   in_bcd    - packed BCD, [3:0] units, [7:4] tens, [11:8] hundreds
//   out_valid - out_bin/out_err hold a result
//   out_ready - consumer takes the result
//   out_bin   - binary value of the accepted word
//   out_err   - accepted word had a nibble greater than 9
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIGIT_W*DIGITS-1:0]  in_bcd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIN_W-1:0]           out_bin,
  output logic                       out_err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  out_bin_q, out_bin_d;
  logic              out_err_q, out_err_d;

  logic [SR_W-1:0]   shifted;
  logic [BCD_W-1:0]  adj_bcd;
  logic              bad_nibble;

  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_nibble_valid(in_bcd[i*DIGIT_W +: DIGIT_W])) begin
        bad_nibble = 1'b1;
      end
    end
  end

  // The whole {bcd, bin} register shifts as one; the bits leaving the BCD
  // field become the next binary LSB-first bit stream.
  assign shifted = sr_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (bad_nibble) begin
            out_bin_d = '0;
            out_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            sr_d      = {in_bcd, {BIN_W{1'b0}}};
            cnt_d     = '0;
            out_err_d = 1'b0;
            state_d   = CONV;
          end
        end
      end
      CONV: begin
        sr_d  = {adj_bcd, shifted[BIN_W-1:0]};
        cnt_d = cnt_q + CNT_W'(1);
        // The final step's freshly shifted bin field is the finished result.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          out_bin_d = shifted[BIN_W-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

endmodule
